// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse, one-shot (DONE) and auto-reload modes.
// All outputs come straight from registers; busy/done are decoded from the state register.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // clr beats load beats en; tc defaults low so it can only be a single-edge pulse.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      state_d  = RUN;
      count_d  = load_val;
      reload_d = load_val;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end else begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                state_d = DONE;
                count_d = '0;
              end
            end
          end
        end
        default: count_d = '0;
      endcase
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: an every-cycle compare against a behavioural model,
// plus hand-computed literal expectations for the directed scenarios.
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             en = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy, tc, done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .auto_reload(auto_reload),
    .count(count), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: a mode word ("idle", "running", "expired") and an integer count.
  int m_mode = 0;   // 0 idle, 1 running, 2 expired
  int m_cnt  = 0;
  int m_rel  = 0;
  bit m_tc   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_cnt <= 0; m_rel <= 0; m_tc <= 1'b0;
    end else if (clr) begin
      m_mode <= 0; m_cnt <= 0; m_tc <= 1'b0;
    end else if (load) begin
      m_mode <= 1; m_cnt <= int'(load_val); m_rel <= int'(load_val); m_tc <= 1'b0;
    end else if (m_mode == 1 && en) begin
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1; m_tc <= 1'b0;
      end else begin
        m_tc <= 1'b1;
        if (auto_reload) m_cnt <= m_rel;
        else m_mode <= 2;
      end
    end else begin
      m_tc <= 1'b0;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", int'(count), m_cnt);
      check("model_busy",  int'(busy),  int'(m_mode == 1));
      check("model_tc",    int'(tc),    int'(m_tc));
      check("model_done",  int'(done),  int'(m_mode == 2));
    end
  end

  // One transaction: drive inputs (we are at a falling edge), pass one rising edge.
  task automatic cycle(input bit r, input bit c, input bit l, input int lv, input bit e, input bit ar);
    rst = r; clr = c; load = l; load_val = WIDTH'(lv); en = e; auto_reload = ar;
    @(negedge clk);
    cyc++;
    $display("cyc %0d: rst=%0b clr=%0b load=%0b lv=%0d en=%0b ar=%0b -> count=%0d busy=%0b tc=%0b done=%0b",
             cyc, r, c, l, lv, e, ar, count, busy, tc, done);
  endtask

  int tc_seen, last_tc, waited;

  initial begin
    @(negedge clk);
    // 1: reset with random side inputs
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
    chk_en = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_done", int'(done), 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("idle_ignores_en", int'(count), 0);

    // 2: one-shot from 3
    cycle(0, 0, 1, 3, 1, 0);
    check("os_load", int'(count), 3);
    cycle(0, 0, 0, 0, 1, 0); check("os_c2", int'(count), 2);
    cycle(0, 0, 0, 0, 1, 0); check("os_c1", int'(count), 1);
    cycle(0, 0, 0, 0, 1, 0); check("os_c0", int'(count), 0);
    check("os_no_tc_yet", int'(tc), 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("os_tc", int'(tc), 1);
    check("os_done", int'(done), 1);
    check("os_busy", int'(busy), 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("os_tc_pulse", int'(tc), 0);
    check("os_done_hold", int'(done), 1);

    // 3: auto-reload from 2, tc every 3 cycles
    cycle(0, 0, 1, 2, 1, 1);
    check("ar_load", int'(count), 2);
    tc_seen = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 0, 1, 1);
      if (tc) tc_seen++;
    end
    check("ar_tc_count", tc_seen, 3);
    check("ar_count_end", int'(count), 2);
    check("ar_busy", int'(busy), 1);

    // 4: en gating
    cycle(0, 0, 1, 5, 1, 0); check("en_load", int'(count), 5);
    cycle(0, 0, 0, 0, 1, 0); check("en_c4", int'(count), 4);
    cycle(0, 0, 0, 0, 0, 0); check("en_hold1", int'(count), 4);
    cycle(0, 0, 0, 0, 0, 0); check("en_hold2", int'(count), 4);
    cycle(0, 0, 0, 0, 1, 0); check("en_c3", int'(count), 3);

    // 5: zero load, then load colliding with terminal count
    cycle(0, 0, 1, 0, 1, 0); check("z_load_busy", int'(busy), 1);
    cycle(0, 0, 0, 0, 1, 0);
    check("z_tc", int'(tc), 1);
    check("z_done", int'(done), 1);
    cycle(0, 0, 1, 1, 1, 1);
    cycle(0, 0, 0, 0, 1, 1); check("col_at_zero", int'(count), 0);
    cycle(0, 0, 1, 7, 1, 1);
    check("col_count", int'(count), 7);
    check("col_no_tc", int'(tc), 0);

    // 6: full-scale period, clr mid-count, rst mid-run
    cycle(0, 0, 1, 15, 1, 1);
    tc_seen = 0; last_tc = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle(0, 0, 0, 0, 1, 1);
      if (tc) begin
        tc_seen++;
        if (last_tc >= 0) check("period16", i - last_tc, 16);
        last_tc = i;
      end
    end
    check("period_pulses", tc_seen, 2);
    waited = 0;
    while (count != 4'd9 && waited < 20) begin
      cycle(0, 0, 0, 0, 1, 1);
      waited++;
    end
    check("reach_9_timeout", int'(count == 4'd9), 1);
    cycle(0, 1, 0, 0, 1, 1);
    check("clr_count", int'(count), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_tc", int'(tc), 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1, 1);
    check("clr_stays_idle", int'(busy), 0);
    cycle(0, 0, 1, 6, 1, 1); check("reload6", int'(count), 6);
    cycle(0, 0, 0, 0, 1, 1); check("reload_c5", int'(count), 5);
    cycle(1, 0, 1, 9, 1, 1);
    check("midrst_count", int'(count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    cycle(0, 0, 0, 0, 1, 1);
    check("midrst_no_tc", int'(tc), 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
